// File: rtl/crt_sync_gen.sv
// CRT raster counters and sync/blank/display-enable generation.
// Flags are registered one pix_clk behind the counters.
module crt_sync_gen #(
  parameter int HW = 12,
  parameter int VW = 12
) (
  input  logic          pix_clk,
  input  logic          h_reset_n,
  input  logic          crt_clk,
  input  logic          timing_en,
  input  logic [HW-1:0] h_total,
  input  logic [HW-1:0] h_disp_end,
  input  logic [HW-1:0] h_sync_start,
  input  logic [HW-1:0] h_sync_end,
  input  logic [VW-1:0] v_total,
  input  logic [VW-1:0] v_disp_end,
  input  logic [VW-1:0] v_sync_start,
  input  logic [VW-1:0] v_sync_end,
  input  logic          hsync_pol,
  input  logic          vsync_pol,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          frame_start
);

  logic adv;
  logic h_wrap;
  logic v_wrap;
  logic hs_n;
  logic vs_n;
  logic hb_n;
  logic vb_n;
  logic hs_q;
  logic vs_q;
  logic pend_q;

  always_comb begin
    adv    = crt_clk & timing_en;
    h_wrap = hcount >= h_total;
    v_wrap = vcount >= v_total;
    hs_n   = (hcount >= h_sync_start) &&
             (hcount < h_sync_end);
    vs_n   = (vcount >= v_sync_start) &&
             (vcount < v_sync_end);
    hb_n   = hcount > h_disp_end;
    vb_n   = vcount > v_disp_end;
  end

  always_ff @(posedge pix_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (!timing_en) begin
      hcount <= '0;
      vcount <= '0;
    end else if (adv) begin
      if (h_wrap) begin
        hcount <= '0;
        vcount <= v_wrap ? '0 : vcount + VW'(1);
      end else begin
        hcount <= hcount + HW'(1);
      end
    end
  end

  always_ff @(posedge pix_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
      de     <= 1'b0;
    end else if (!timing_en) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      hblank <= 1'b1;
      vblank <= 1'b1;
      de     <= 1'b0;
    end else begin
      hs_q   <= hs_n;
      vs_q   <= vs_n;
      hblank <= hb_n;
      vblank <= vb_n;
      de     <= !hb_n && !vb_n;
    end
  end

  // pend_q marks the first advance after reset or a timing_en drop
  always_ff @(posedge pix_clk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      frame_start <= 1'b0;
      pend_q      <= 1'b1;
    end else if (!timing_en) begin
      frame_start <= 1'b0;
      pend_q      <= 1'b1;
    end else if (adv) begin
      frame_start <= pend_q | (h_wrap & v_wrap);
      pend_q      <= 1'b0;
    end else begin
      frame_start <= 1'b0;
    end
  end

  // polarity applied at the pin so reset shows the inactive level
  assign hsync = hs_q ^ hsync_pol;
  assign vsync = vs_q ^ vsync_pol;

endmodule

// File: tb/tb_crt_sync_gen.sv
// Directed bench for crt_sync_gen with a small cycle model.
// Model tracks counters, lagged flags and frame_start.
module tb_crt_sync_gen;

  logic        pix_clk = 1'b0;
  logic        rst_n;
  logic        crt;
  logic        te;
  logic [11:0] ht, hde, hss, hse;
  logic [11:0] vt, vde, vss, vse;
  logic        hpol, vpol;
  logic [11:0] hcount, vcount;
  logic        hsync, vsync, hblank, vblank;
  logic        de, frame_start;

  int checks = 0;
  int errors = 0;
  int m_h, m_v;
  bit m_pend;
  bit e_hs, e_vs, e_hb, e_vb, e_de, e_fs;
  int cyc = 0;
  int last_fs = -1;
  int exp_period = 0;
  int bad, v0;
  bit hit;

  crt_sync_gen #(.HW(12), .VW(12)) dut (
    .pix_clk     (pix_clk),
    .h_reset_n   (rst_n),
    .crt_clk     (crt),
    .timing_en   (te),
    .h_total     (ht),
    .h_disp_end  (hde),
    .h_sync_start(hss),
    .h_sync_end  (hse),
    .v_total     (vt),
    .v_disp_end  (vde),
    .v_sync_start(vss),
    .v_sync_end  (vse),
    .hsync_pol   (hpol),
    .vsync_pol   (vpol),
    .hcount      (hcount),
    .vcount      (vcount),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblank      (hblank),
    .vblank      (vblank),
    .de          (de),
    .frame_start (frame_start)
  );

  always #5 pix_clk = ~pix_clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    int ph, pv;
    bit hw, vw;
    @(posedge pix_clk);
    ph = m_h;
    pv = m_v;
    if (!te) begin
      m_h = 0; m_v = 0;
      e_hs = 0; e_vs = 0;
      e_hb = 1; e_vb = 1;
      e_de = 0; e_fs = 0;
      m_pend = 1;
    end else begin
      e_hs = (ph >= int'(hss)) && (ph < int'(hse));
      e_vs = (pv >= int'(vss)) && (pv < int'(vse));
      e_hb = ph > int'(hde);
      e_vb = pv > int'(vde);
      e_de = !e_hb && !e_vb;
      e_fs = 0;
      if (crt) begin
        hw = ph >= int'(ht);
        vw = pv >= int'(vt);
        e_fs = m_pend || (hw && vw);
        m_pend = 0;
        if (hw) begin
          m_h = 0;
          m_v = vw ? 0 : pv + 1;
        end else begin
          m_h = ph + 1;
        end
      end
    end
    #1;
    cyc++;
    check("hcount", hcount, m_h);
    check("vcount", vcount, m_v);
    check("hsync", hsync, e_hs ^ hpol);
    check("vsync", vsync, e_vs ^ vpol);
    check("hblank", hblank, e_hb);
    check("vblank", vblank, e_vb);
    check("de", de, e_de);
    check("frame_start", frame_start, e_fs);
    if (frame_start) begin
      if (last_fs >= 0 && exp_period > 0)
        check("period", cyc - last_fs, exp_period);
      last_fs = cyc;
    end
  endtask

  initial begin
    rst_n = 0; te = 0; crt = 1;
    ht = 9; hde = 7; hss = 8; hse = 9;
    vt = 4; vde = 2; vss = 3; vse = 4;
    hpol = 0; vpol = 0;
    m_h = 0; m_v = 0; m_pend = 1;
    #23;
    check("rst_h", hcount, 0);
    check("rst_v", vcount, 0);
    check("rst_hb", hblank, 1);
    check("rst_vb", vblank, 1);
    check("rst_de", de, 0);
    check("rst_fs", frame_start, 0);
    check("rst_hs", hsync, 0);
    check("rst_vs", vsync, 0);
    @(negedge pix_clk);
    rst_n = 1;
    step(); step();

    // divide-by-1 mode, 50-cycle frame
    te = 1;
    step();
    check("fs_first", frame_start, 1);
    last_fs = -1;
    exp_period = 50;
    repeat (160) step();

    // one advance every 4 pixel clocks
    last_fs = -1;
    exp_period = 200;
    for (int k = 0; k < 460; k++) begin
      crt = (k % 4 == 0);
      step();
    end
    crt = 1;
    exp_period = 0;

    // shrink h_total below current hcount
    hit = 0;
    for (int k = 0; k < 100 && !hit; k++) begin
      step();
      hit = (m_h == 9);
    end
    check("reach_h9", hit, 1);
    v0 = m_v;
    ht = 5;
    step();
    check("h_short_wrap", hcount, 0);
    check("v_short_inc", vcount,
          (v0 >= 4) ? 0 : v0 + 1);
    ht = 9;
    repeat (12) step();

    // disabled timing with polarity
    hpol = 1; vpol = 0; te = 0;
    step(); step();
    check("dis_hs", hsync, 1);
    check("dis_vs", vsync, 0);
    check("dis_de", de, 0);
    check("dis_hb", hblank, 1);
    check("dis_vb", vblank, 1);
    check("dis_h", hcount, 0);
    check("dis_v", vcount, 0);
    te = 1;
    step();
    check("fs_en", frame_start, 1);
    repeat (20) step();

    // asynchronous reset mid-line
    hpol = 0;
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      step();
      hit = (m_h == 6) && (m_v == 2);
    end
    check("reach_6_2", hit, 1);
    #3;
    rst_n = 0;
    #1;
    check("arst_h", hcount, 0);
    check("arst_v", vcount, 0);
    check("arst_hb", hblank, 1);
    check("arst_vb", vblank, 1);
    check("arst_de", de, 0);
    check("arst_fs", frame_start, 0);
    check("arst_hs", hsync, hpol);
    check("arst_vs", vsync, vpol);
    m_h = 0; m_v = 0; m_pend = 1;
    te = 0;
    repeat (2) @(posedge pix_clk);
    @(negedge pix_clk);
    rst_n = 1;
    step();
    te = 1;
    step();
    check("rst_restart_h", hcount, 1);
    check("rst_restart_v", vcount, 0);
    repeat (10) step();

    // empty sync window
    hss = 5; hse = 5;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (hsync !== hpol) bad++;
    end
    check("hs_const", bad, 0);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
